// File: rtl/trees_batch_ctrl.sv
// Batch sequencer for the tree-ensemble inference block: loads features, starts, waits, drains predictions.
// Optional perf counter is enabled by defining TREES_BATCH_PERF_EN.
module trees_batch_ctrl #(
    parameter int  N_FEATURE      = 32,
    parameter int  MAX_BURST      = 5000,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int BL_W           = $clog2(MAX_BURST),
    localparam int ADDR_W         = $clog2(MAX_BURST*N_FEATURE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BL_W-1:0]   cmd_burst_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic              out_last,
    output logic              acc_load_features,
    output logic [ADDR_W-1:0] acc_feature_addr,
    output logic [63:0]       acc_features2,
    output logic [BL_W-1:0]   acc_burst_len,
    output logic              acc_start,
    input  logic              acc_done,
    input  logic [63:0]       acc_prediction,
    output logic [BL_W-1:0]   acc_prediction_addr,
    output logic              busy,
    output logic              job_done,
    output logic              job_err,
`ifdef TREES_BATCH_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    output logic [2:0]        dbg_state
);

    localparam int              HALF    = N_FEATURE / 2;
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BL_W:0]   MAX_BL  = (BL_W+1)'(MAX_BURST);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] total_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic [BL_W-1:0]   nwords_q;
    logic [BL_W-1:0]   drain_idx_q;
    logic [BL_W-1:0]   burst_len_q;
    logic [WD_W-1:0]   wdog_q;
    logic              load_q;
    logic [ADDR_W-1:0] faddr_q;
    logic [63:0]       fdata_q;
    logic              start_q;
    logic              last_q;
    logic              done_q;
    logic              err_q;
`ifdef TREES_BATCH_PERF_EN
    logic [31:0]       perf_q;
`endif

    logic              cmd_hs;
    logic              in_hs;
    logic              out_hs;
    logic              len_bad;
    logic              last_word;
    logic              wdog_expired;
    logic [ADDR_W-1:0] total_d;
    logic [BL_W-1:0]   nwords_d;
    logic [BL_W-1:0]   drain_idx_d;
    logic              drain_last_d;

    // Every stream here transfers a beat on a cycle where valid & ready are both high at the
    // clock edge; valid never depends on ready, and the sender holds its payload while stalled.
    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    assign len_bad      = (cmd_burst_len == '0) || ({1'b0, cmd_burst_len} > MAX_BL);
    assign total_d      = ADDR_W'(cmd_burst_len) * ADDR_W'(HALF);
    assign nwords_d     = BL_W'(({1'b0, cmd_burst_len} + (BL_W+1)'(7)) >> 3);
    assign last_word    = (wcnt_q == total_q - ADDR_W'(1));
    assign wdog_expired = (wdog_q == WD_LAST);
    assign drain_idx_d  = drain_idx_q + BL_W'(1);
    assign drain_last_d = (drain_idx_d == nwords_q - BL_W'(1));

    assign acc_load_features   = load_q;
    assign acc_feature_addr    = faddr_q;
    assign acc_features2       = fdata_q;
    assign acc_burst_len       = burst_len_q;
    assign acc_start           = start_q;
    assign acc_prediction_addr = drain_idx_q;
    assign out_data            = (state_q == S_DRAIN) ? acc_prediction : '0;
    assign out_last            = last_q;
    assign job_done            = done_q;
    assign job_err             = err_q;
`ifdef TREES_BATCH_PERF_EN
    assign perf_cycles         = perf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            wcnt_q      <= '0;
            nwords_q    <= '0;
            drain_idx_q <= '0;
            burst_len_q <= '0;
            wdog_q      <= '0;
            load_q      <= 1'b0;
            faddr_q     <= '0;
            fdata_q     <= '0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef TREES_BATCH_PERF_EN
            perf_q      <= '0;
`endif
        end else begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // Abort outranks every other event and drops all strobes on the next edge.
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_hs) begin
                            if (len_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                burst_len_q <= cmd_burst_len;
                                total_q     <= total_d;
                                nwords_q    <= nwords_d;
                                wcnt_q      <= '0;
                                drain_idx_q <= '0;
                                wdog_q      <= '0;
`ifdef TREES_BATCH_PERF_EN
                                perf_q      <= '0;
`endif
                                state_q     <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (in_hs) begin
                            load_q  <= 1'b1;
                            faddr_q <= wcnt_q;
                            fdata_q <= in_data;
                            wcnt_q  <= wcnt_q + ADDR_W'(1);
                            if (last_word) begin
                                state_q <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        start_q <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
`ifdef TREES_BATCH_PERF_EN
                        if (perf_q != '1) begin
                            perf_q <= perf_q + 32'd1;
                        end
`endif
                        // acc_done wins over a watchdog expiry in the same cycle.
                        if (acc_done) begin
                            state_q     <= S_DRAIN;
                            drain_idx_q <= '0;
                            last_q      <= (nwords_q == BL_W'(1));
                        end else if (wdog_expired) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + WD_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (out_hs) begin
                            if (last_q) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                                last_q  <= 1'b0;
                            end else begin
                                drain_idx_q <= drain_idx_d;
                                last_q      <= drain_last_d;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trees_batch_ctrl.sv
// Self-checking bench for trees_batch_ctrl: vector table, random jobs, and multi-cycle corner sequences.
module tb_trees_batch_ctrl;

    localparam int N_FEATURE  = 32;
    localparam int MAX_BURST  = 5000;
    localparam int TB_TIMEOUT = 50;
    localparam int HALF       = N_FEATURE / 2;
    localparam int BL_W       = $clog2(MAX_BURST);
    localparam int ADDR_W     = $clog2(MAX_BURST*N_FEATURE);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [BL_W-1:0]   cmd_burst_len = '0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [63:0]       in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [63:0]       out_data;
    logic              out_last;
    logic              acc_load_features;
    logic [ADDR_W-1:0] acc_feature_addr;
    logic [63:0]       acc_features2;
    logic [BL_W-1:0]   acc_burst_len;
    logic              acc_start;
    logic              acc_done = 1'b0;
    logic [63:0]       acc_prediction;
    logic [BL_W-1:0]   acc_prediction_addr;
    logic              busy;
    logic              job_done;
    logic              job_err;
    logic [2:0]        dbg_state;
`ifdef TREES_BATCH_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    logic [63:0] pred_mem [0:(1<<BL_W)-1];
    assign acc_prediction = pred_mem[acc_prediction_addr];

    logic [63:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [63:0]       exp_data_q[$];

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    trees_batch_ctrl #(
        .N_FEATURE(N_FEATURE),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_burst_len(cmd_burst_len),
        .abort(abort),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .acc_load_features(acc_load_features),
        .acc_feature_addr(acc_feature_addr),
        .acc_features2(acc_features2),
        .acc_burst_len(acc_burst_len),
        .acc_start(acc_start),
        .acc_done(acc_done),
        .acc_prediction(acc_prediction),
        .acc_prediction_addr(acc_prediction_addr),
        .busy(busy),
        .job_done(job_done),
        .job_err(job_err),
`ifdef TREES_BATCH_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the feature-memory write port
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_start) start_cnt++;
            if (acc_load_features) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_strobe", acc_load_features, 1'b0);
                end else begin
                    check("wr_addr", acc_feature_addr, exp_addr_q.pop_front());
                    check("wr_data", acc_features2, exp_data_q.pop_front());
                    check("wr_no_start", acc_start, 1'b0);
                end
            end
        end
    end

    // mode 0: full job; mode 1: stop once in DRAIN; mode 2: never assert acc_done
    task automatic run_job(input int len, input int exp_nw, input int gap_pct, input int rdy_pct, input int mode);
        int          tot;
        int          sent;
        int          cyc;
        int          idx;
        int          n;
        int          starts0;
        logic        r;
        logic        v;
        logic        rdy;
        logic        stalled;
        logic [63:0] w;
        logic [63:0] prev_data;
        logic        prev_last;
        tot = len * HALF;
        sent = 0;
        for (int i = 0; i <= exp_nw; i++) pred_mem[i] = {$urandom(), $urandom()};
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_burst_len = BL_W'(len);
        tick();
        cmd_valid = 1'b0;
        check("busy_after_cmd", busy, 1'b1);
        check("cmd_ready_busy", cmd_ready, 1'b0);
        check("acc_burst_len", acc_burst_len, 64'(len));
        check("in_ready_load", in_ready, 1'b1);
        starts0 = start_cnt;
        cyc = 0;
        while (sent < tot && cyc < 20000) begin
            r = in_ready;
            v = ($urandom_range(0, 99) >= gap_pct);
            w = {$urandom(), $urandom()};
            in_valid = v;
            in_data = w;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_burst_len = BL_W'($urandom_range(1, 40));
            tick();
            cyc++;
            if (v && r) begin
                exp_addr_q.push_back(ADDR_W'(sent));
                exp_data_q.push_back(w);
                sent++;
            end
        end
        in_valid = 1'b0;
        cmd_valid = 1'b0;
        check("load_count", 64'(sent), 64'(tot));
        check("in_ready_drop", in_ready, 1'b0);
        check("start_not_with_load", acc_start, 1'b0);
        tick();
        check("acc_start_pulse", acc_start, 1'b1);
        check("no_load_at_start", acc_load_features, 1'b0);
        check("burst_len_held", acc_burst_len, 64'(len));
        if (mode == 2) begin
            n = 0;
            while (!job_err && n < 200) begin
                tick();
                n++;
            end
            check("timeout_cycles", 64'(n), 64'(TB_TIMEOUT));
            check("timeout_idle", busy, 1'b0);
            check("timeout_cmd_ready", cmd_ready, 1'b1);
            tick();
            check("timeout_err_pulse", job_err, 1'b0);
            check("timeout_no_done", job_done, 1'b0);
        end else begin
            tick();
            check("acc_start_once", acc_start, 1'b0);
            repeat ($urandom_range(0, 5)) tick();
            acc_done = 1'b1;
            tick();
            acc_done = 1'b0;
            check("start_count", 64'(start_cnt - starts0), 64'd1);
            check("all_writes_seen", 64'(exp_addr_q.size()), 64'd0);
            check("drain_valid", out_valid, 1'b1);
            check("drain_addr0", acc_prediction_addr, '0);
            if (mode == 0) begin
                for (int i = 0; i < exp_nw; i++) exp_q.push_back(pred_mem[i]);
                idx = 0;
                cyc = 0;
                stalled = 1'b0;
                prev_data = '0;
                prev_last = 1'b0;
                while (idx < exp_nw && cyc < 2000) begin
                    if (stalled) begin
                        check("stall_data", out_data, prev_data);
                        check("stall_last", out_last, prev_last);
                    end
                    rdy = ($urandom_range(0, 99) < rdy_pct);
                    out_ready = rdy;
                    if (rdy) begin
                        check("out_valid", out_valid, 1'b1);
                        check("out_data", out_data, exp_q.pop_front());
                        check("out_last", out_last, 64'(idx == exp_nw - 1));
                        check("pred_addr", acc_prediction_addr, 64'(idx));
                        idx++;
                    end
                    prev_data = out_data;
                    prev_last = out_last;
                    stalled = !rdy;
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
                check("drain_count", 64'(idx), 64'(exp_nw));
                check("job_done", job_done, 1'b1);
                check("done_idle", busy, 1'b0);
                check("done_cmd_ready", cmd_ready, 1'b1);
                check("done_out_valid", out_valid, 1'b0);
                check("done_no_err", job_err, 1'b0);
                tick();
                check("job_done_pulse", job_done, 1'b0);
            end
        end
    endtask

    task automatic run_reject(input int len);
        check("rej_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_burst_len = BL_W'(len);
        tick();
        cmd_valid = 1'b0;
        check("rej_err", job_err, 1'b1);
        check("rej_busy", busy, 1'b0);
        check("rej_in_ready", in_ready, 1'b0);
        tick();
        check("rej_err_pulse", job_err, 1'b0);
        check("rej_busy2", busy, 1'b0);
    endtask

    typedef struct {
        int len;
        bit legal;
        int nwords;
        int gap_pct;
        int rdy_pct;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int len;
        int starts0;
        vecs[0] = '{3, 1'b1, 1, 0, 100};
        vecs[1] = '{0, 1'b0, 0, 0, 100};
        vecs[2] = '{5001, 1'b0, 0, 0, 100};
        vecs[3] = '{17, 1'b1, 3, 20, 50};
        vecs[4] = '{8, 1'b1, 1, 0, 40};
        vecs[5] = '{9, 1'b1, 2, 30, 70};
        vecs[6] = '{1, 1'b1, 1, 50, 100};
        vecs[7] = '{8191, 1'b0, 0, 0, 100};
        vecs[8] = '{16, 1'b1, 2, 10, 30};
        vecs[9] = '{64, 1'b1, 8, 0, 60};
        for (int i = 0; i < (1 << BL_W); i++) pred_mem[i] = '0;

        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_state", dbg_state, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].legal) run_job(vecs[i].len, vecs[i].nwords, vecs[i].gap_pct, vecs[i].rdy_pct, 0);
            else run_reject(vecs[i].len);
        end

        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(0, 40);
            if (len == 0) run_reject(len);
            else run_job(len, (len + 7) / 8, $urandom_range(0, 50), $urandom_range(30, 100), 0);
        end
        run_reject($urandom_range(MAX_BURST + 1, (1 << BL_W) - 1));

        // abort is ignored while idle
        abort = 1'b1;
        tick();
        check("abort_idle_err", job_err, 1'b0);
        check("abort_idle_busy", busy, 1'b0);
        abort = 1'b0;

        run_job(2, 1, 0, 100, 2);

        // Abort in LOAD after 10 words
        starts0 = start_cnt;
        cmd_valid = 1'b1;
        cmd_burst_len = BL_W'(3);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = {$urandom(), $urandom()};
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", busy, 1'b0);
        check("abort_err", job_err, 1'b1);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        check("abort_no_load", acc_load_features, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        tick();
        check("abort_err_pulse", job_err, 1'b0);
        repeat (5) tick();
        check("abort_no_start", 64'(start_cnt - starts0), 64'd0);
        check("abort_writes_seen", 64'(exp_addr_q.size()), 64'd0);
        run_job(3, 1, 0, 100, 0);

        // Asynchronous reset in the middle of DRAIN
        run_job(17, 3, 0, 100, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_data", out_data, '0);
        check("arst_out_last", out_last, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_load", acc_load_features, 1'b0);
        check("arst_faddr", acc_feature_addr, '0);
        check("arst_fdata", acc_features2, '0);
        check("arst_burst_len", acc_burst_len, '0);
        check("arst_start", acc_start, 1'b0);
        check("arst_pred_addr", acc_prediction_addr, '0);
        check("arst_done", job_done, 1'b0);
        check("arst_err", job_err, 1'b0);
        check("arst_state", dbg_state, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_job(17, 3, 10, 50, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout act=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
